// File: rtl/breakout_engine.sv
// breakout_engine: frame-rate breakout game core. Runs ball, paddle, brick grid,
// lives, score and pause once per frame (on the last active pixel) and renders
// RGB565 pixels with one cycle of registered latency.
module breakout_engine #(
    parameter int H_VALID      = 640,
    parameter int V_VALID      = 480,
    parameter int BRICK_COLS   = 8,
    parameter int BRICK_ROWS   = 5,
    parameter int BRICK_W      = 60,
    parameter int BRICK_H      = 20,
    parameter int BRICK_GAP    = 4,
    parameter int BRICK_X0     = 40,
    parameter int BRICK_Y0     = 150,
    parameter int LIVES        = 3,
    parameter int BALL_R       = 10,
    parameter int BALL_SPEED   = 4,
    parameter int PADDLE_W     = 80,
    parameter int PADDLE_H     = 10,
    parameter int PADDLE_SPEED = 8
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_start,
    output logic [15:0] pix_data,
    output logic [15:0] score,
    output logic [2:0]  lives,
    output logic [2:0]  game_state
);

    localparam int NB = BRICK_COLS * BRICK_ROWS;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_PAUSE = 3'd3,
        S_OVER  = 3'd4,
        S_WIN   = 3'd5
    } state_t;

    // 11-bit signed coordinates so that subtraction near 0 never wraps into a hit
    typedef logic signed [10:0] coord_t;

    localparam coord_t C_ONE      = coord_t'(1);
    localparam coord_t C_R        = coord_t'(BALL_R);
    localparam coord_t C_SPD      = coord_t'(BALL_SPEED);
    localparam coord_t C_XMAX     = coord_t'(H_VALID - 1 - BALL_R);
    localparam coord_t C_MISS_Y   = coord_t'(V_VALID - BALL_R);
    localparam coord_t C_PAD_TOP  = coord_t'(V_VALID - PADDLE_H);
    localparam coord_t C_PAD_REST = coord_t'(V_VALID - PADDLE_H - BALL_R - 1);
    localparam coord_t C_HALF_PW  = coord_t'(PADDLE_W / 2);
    localparam coord_t C_SIXTH_PW = coord_t'(PADDLE_W / 6);
    localparam coord_t C_PMAX     = coord_t'(H_VALID - 1 - PADDLE_W / 2);
    localparam coord_t C_PSPD     = coord_t'(PADDLE_SPEED);
    localparam coord_t C_BALL_X0  = coord_t'(H_VALID / 2);
    localparam coord_t C_BALL_Y0  = coord_t'(V_VALID / 4);
    localparam coord_t C_BW1      = coord_t'(BRICK_W - 1);
    localparam coord_t C_BH1      = coord_t'(BRICK_H - 1);
    localparam coord_t C_LIFE_Y0  = coord_t'(4);
    localparam coord_t C_LIFE_Y1  = coord_t'(11);

    localparam logic [15:0] COL_BLACK = 16'h0000;
    localparam logic [15:0] COL_WHITE = 16'hFFFF;
    localparam logic [15:0] COL_RED   = 16'hF800;
    localparam logic [15:0] COL_GREEN = 16'h07E0;
    localparam logic [15:0] COL_BLUE  = 16'h001F;

    function automatic coord_t brick_x(input int c);
        return coord_t'(BRICK_X0 + c * (BRICK_W + BRICK_GAP));
    endfunction

    function automatic coord_t brick_y(input int r);
        return coord_t'(BRICK_Y0 + r * (BRICK_H + BRICK_GAP));
    endfunction

    function automatic logic [15:0] row_color(input int r);
        case (r)
            0:       return 16'hFD20;
            1:       return 16'hFFE0;
            2:       return 16'h07E0;
            3:       return 16'h07FF;
            4:       return 16'h001F;
            5:       return 16'h781F;
            6:       return 16'hF81F;
            default: return 16'h8410;
        endcase
    endfunction

    state_t          state;
    coord_t          ball_x, ball_y, paddle_x;
    logic            dx_right, dy_down;
    logic [NB-1:0]   bricks;
    logic [1:0]      left_sync, right_sync, start_sync;
    logic            start_prev, start_pend;

    logic            tick, start_press, start_req, left_held, right_held;
    coord_t          nx, ny, pdiff, pabs, paddle_nx, px, py;
    logic            ndx, ndy, paddle_hit, miss, brick_hit, last_clear;
    logic [NB-1:0]   clear_mask;
    logic [15:0]     color;

    assign game_state  = state;
    assign tick        = (pix_x == 10'(H_VALID - 1)) && (pix_y == 10'(V_VALID - 1));
    assign start_press = start_prev & ~start_sync[1];
    assign start_req   = start_pend | start_press;
    assign left_held   = ~left_sync[1];
    assign right_held  = ~right_sync[1];
    assign last_clear  = brick_hit && ((bricks & ~clear_mask) == '0);

    // Button synchronisers, start edge detect and the start request held until the next tick
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            left_sync  <= 2'b11;
            right_sync <= 2'b11;
            start_sync <= 2'b11;
            start_prev <= 1'b1;
            start_pend <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its neighbour.
            left_sync  <= {left_sync[0], btn_left};
            right_sync <= {right_sync[0], btn_right};
            start_sync <= {start_sync[0], btn_start};
            start_prev <= start_sync[1];
            start_pend <= tick ? 1'b0 : (start_pend | start_press);
        end
    end

    // Candidate ball step for this frame: walls, top, paddle, miss, then first overlapped brick
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        nx         = dx_right ? ball_x + C_SPD : ball_x - C_SPD;
        ny         = dy_down  ? ball_y + C_SPD : ball_y - C_SPD;
        ndx        = dx_right;
        ndy        = dy_down;
        paddle_hit = 1'b0;
        brick_hit  = 1'b0;
        clear_mask = '0;
        if (nx <= C_R) begin
            ndx = ~dx_right;
            nx  = C_R + C_ONE;
        end else if (nx >= C_XMAX) begin
            ndx = ~dx_right;
            nx  = C_XMAX - C_ONE;
        end
        if (ny <= C_R) begin
            ndy = 1'b1;
            ny  = C_R + C_ONE;
        end
        pdiff = nx - paddle_x;
        pabs  = pdiff[10] ? -pdiff : pdiff;
        if (dy_down && (ny + C_R >= C_PAD_TOP) && (pabs <= C_HALF_PW)) begin
            paddle_hit = 1'b1;
            ndy        = 1'b0;
            ny         = C_PAD_REST;
            if (pdiff < -C_SIXTH_PW)
                ndx = 1'b0;
            else if (pdiff > C_SIXTH_PW)
                ndx = 1'b1;
        end
        miss = !paddle_hit && (ny >= C_MISS_Y);
        if (!miss) begin
            for (int r = 0; r < BRICK_ROWS; r++) begin
                for (int c = 0; c < BRICK_COLS; c++) begin
                    if (!brick_hit && bricks[r * BRICK_COLS + c]
                        && (nx - C_R <= brick_x(c) + C_BW1) && (nx + C_R >= brick_x(c))
                        && (ny - C_R <= brick_y(r) + C_BH1) && (ny + C_R >= brick_y(r))) begin
                        brick_hit                    = 1'b1;
                        clear_mask[r * BRICK_COLS + c] = 1'b1;
                    end
                end
            end
        end
        if (brick_hit)
            ndy = ~ndy;
    end

    // Paddle step from the held buttons, centre clamped to the screen
    always_comb begin
        paddle_nx = paddle_x;
        if (left_held && !right_held)
            paddle_nx = paddle_x - C_PSPD;
        else if (right_held && !left_held)
            paddle_nx = paddle_x + C_PSPD;
        if (paddle_nx < C_HALF_PW)
            paddle_nx = C_HALF_PW;
        else if (paddle_nx > C_PMAX)
            paddle_nx = C_PMAX;
    end

    // Game FSM and all frame state, updated only on the frame tick
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= S_IDLE;
            ball_x   <= C_BALL_X0;
            ball_y   <= C_BALL_Y0;
            dx_right <= 1'b1;
            dy_down  <= 1'b1;
            paddle_x <= coord_t'(H_VALID / 2);
            // NOTE: the brick map is a plain register vector, not a RAM, so it resets with the rest.
            bricks   <= '1;
            score    <= '0;
            lives    <= 3'(LIVES);
        end else if (tick) begin
            case (state)
                S_IDLE: begin
                    if (start_req) begin
                        state    <= S_SERVE;
                        ball_x   <= C_BALL_X0;
                        ball_y   <= C_BALL_Y0;
                        dx_right <= 1'b1;
                        dy_down  <= 1'b1;
                    end
                end
                S_SERVE: begin
                    paddle_x <= paddle_nx;
                    if (start_req)
                        state <= S_PLAY;
                end
                S_PLAY: begin
                    // start takes the whole tick: the pause freezes the frame it arrives in
                    if (start_req) begin
                        state <= S_PAUSE;
                    end else begin
                        paddle_x <= paddle_nx;
                        if (miss) begin
                            lives    <= lives - 3'd1;
                            state    <= (lives > 3'd1) ? S_SERVE : S_OVER;
                            ball_x   <= C_BALL_X0;
                            ball_y   <= C_BALL_Y0;
                            dx_right <= 1'b1;
                            dy_down  <= 1'b1;
                        end else begin
                            ball_x   <= nx;
                            ball_y   <= ny;
                            dx_right <= ndx;
                            dy_down  <= ndy;
                            bricks   <= bricks & ~clear_mask;
                            if (brick_hit && score != 16'hFFFF)
                                score <= score + 16'd1;
                            if (last_clear)
                                state <= S_WIN;
                        end
                    end
                end
                S_PAUSE: begin
                    if (start_req)
                        state <= S_PLAY;
                end
                S_OVER, S_WIN: begin
                    if (start_req) begin
                        state    <= S_SERVE;
                        bricks   <= '1;
                        score    <= '0;
                        lives    <= 3'(LIVES);
                        ball_x   <= C_BALL_X0;
                        ball_y   <= C_BALL_Y0;
                        dx_right <= 1'b1;
                        dy_down  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Pixel colour: paddle > ball > brick > lives > background, pause blanks odd lines
    always_comb begin
        px = $signed({1'b0, pix_x});
        py = $signed({1'b0, pix_y});
        case (state)
            S_IDLE:  color = COL_BLUE;
            S_OVER:  color = COL_RED;
            S_WIN:   color = COL_GREEN;
            default: color = COL_WHITE;
        endcase
        for (int k = 0; k < 7; k++) begin
            if ((3'(k) < lives) && py >= C_LIFE_Y0 && py <= C_LIFE_Y1
                && px >= coord_t'(4 + 12 * k) && px <= coord_t'(11 + 12 * k))
                color = COL_RED;
        end
        for (int r = 0; r < BRICK_ROWS; r++) begin
            for (int c = 0; c < BRICK_COLS; c++) begin
                if (bricks[r * BRICK_COLS + c]
                    && px >= brick_x(c) && px <= brick_x(c) + C_BW1
                    && py >= brick_y(r) && py <= brick_y(r) + C_BH1)
                    color = row_color(r);
            end
        end
        if (px >= ball_x - C_R && px <= ball_x + C_R && py >= ball_y - C_R && py <= ball_y + C_R)
            color = COL_RED;
        if (py >= C_PAD_TOP && px >= paddle_x - C_HALF_PW && px < paddle_x + C_HALF_PW)
            color = COL_BLACK;
        if (state == S_PAUSE && pix_y[0])
            color = COL_BLACK;
    end

    // Registered pixel output
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            pix_data <= '0;
        else
            pix_data <= color;
    end

endmodule

// File: tb/tb_breakout_engine.sv
// tb_breakout_engine: directed bench for breakout_engine. Frames are compressed by
// driving pix_x/pix_y straight to the last active pixel for one cycle per frame.
// Three instances: A (grid out of the ball path: paddle, miss, pause, render),
// B (two bricks straddled by the first ball contact), C (single brick -> WIN).
module tb_breakout_engine;

    logic        vga_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [9:0]  pix_x = '0;
    logic [9:0]  pix_y = '0;
    logic        left_a = 1'b1, right_a = 1'b1, start_a = 1'b1;
    logic        start_b = 1'b1, start_c = 1'b1;
    logic        idle_btn = 1'b1;
    logic [15:0] pix_a, pix_b, pix_c, score_a, score_b, score_c;
    logic [2:0]  lives_a, lives_b, lives_c, state_a, state_b, state_c;

    int n_tests = 0;
    int n_fail  = 0;

    breakout_engine #(.BRICK_COLS(2), .BRICK_ROWS(1), .BRICK_X0(40), .BRICK_Y0(20)) dut_a (
        .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .pix_x(pix_x), .pix_y(pix_y),
        .btn_left(left_a), .btn_right(right_a), .btn_start(start_a),
        .pix_data(pix_a), .score(score_a), .lives(lives_a), .game_state(state_a));

    breakout_engine #(.BRICK_COLS(2), .BRICK_ROWS(1), .BRICK_X0(280), .BRICK_Y0(150)) dut_b (
        .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .pix_x(pix_x), .pix_y(pix_y),
        .btn_left(idle_btn), .btn_right(idle_btn), .btn_start(start_b),
        .pix_data(pix_b), .score(score_b), .lives(lives_b), .game_state(state_b));

    breakout_engine #(.BRICK_COLS(1), .BRICK_ROWS(1), .BRICK_X0(280), .BRICK_Y0(150)) dut_c (
        .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .pix_x(pix_x), .pix_y(pix_y),
        .btn_left(idle_btn), .btn_right(idle_btn), .btn_start(start_c),
        .pix_data(pix_c), .score(score_c), .lives(lives_c), .game_state(state_c));

    always #5 vga_clk = ~vga_clk;

    typedef struct {
        int          x;
        int          y;
        logic [15:0] exp;
    } pix_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge vga_clk);
    endtask

    // one compressed frame: a single cycle on the last active pixel
    task automatic do_tick();
        @(negedge vga_clk);
        pix_x = 10'd639;
        pix_y = 10'd479;
        @(negedge vga_clk);
        pix_x = 10'd0;
        pix_y = 10'd0;
    endtask

    task automatic press(input int inst);
        case (inst)
            0: start_a = 1'b0;
            1: start_b = 1'b0;
            default: start_c = 1'b0;
        endcase
        idle(4);
        start_a = 1'b1;
        start_b = 1'b1;
        start_c = 1'b1;
        idle(4);
    endtask

    task automatic ticks(input int n);
        repeat (n) do_tick();
    endtask

    task automatic pix_a_at(input int x, input int y, input logic [15:0] exp, input string name);
        @(negedge vga_clk);
        pix_x = 10'(x);
        pix_y = 10'(y);
        @(negedge vga_clk);
        check(name, 32'(pix_a), 32'(exp));
        pix_x = 10'd0;
        pix_y = 10'd0;
    endtask

    task automatic run_until_lives_change(input int budget, output int n);
        logic [2:0] l0;
        l0 = lives_a;
        n  = 0;
        while (lives_a == l0 && n < budget) begin
            do_tick();
            n++;
        end
    endtask

    pix_vec_t vecs [16];
    int       nframes;

    initial begin
        // render vectors for instance A in IDLE right after reset (lives = 3)
        vecs[0]  = '{0,   0,   16'h001F};
        vecs[1]  = '{4,   4,   16'hF800};
        vecs[2]  = '{11,  11,  16'hF800};
        vecs[3]  = '{12,  4,   16'h001F};
        vecs[4]  = '{28,  8,   16'hF800};
        vecs[5]  = '{40,  8,   16'h001F};
        vecs[6]  = '{40,  20,  16'hFD20};
        vecs[7]  = '{99,  39,  16'hFD20};
        vecs[8]  = '{100, 30,  16'h001F};
        vecs[9]  = '{104, 39,  16'hFD20};
        vecs[10] = '{104, 40,  16'h001F};
        vecs[11] = '{320, 120, 16'hF800};
        vecs[12] = '{331, 120, 16'h001F};
        vecs[13] = '{280, 470, 16'h0000};
        vecs[14] = '{360, 479, 16'h001F};
        vecs[15] = '{320, 469, 16'h001F};

        idle(3);
        check("rst_pix_data", 32'(pix_a), 32'd0);
        check("rst_score",    32'(score_a), 32'd0);
        check("rst_lives",    32'(lives_a), 32'd3);
        check("rst_state",    32'(state_a), 32'd0);
        check("rst_bricks",   32'(dut_a.bricks), 32'b11);
        check("rst_ball_x",   32'(dut_a.ball_x), 32'd320);
        check("rst_ball_y",   32'(dut_a.ball_y), 32'd120);
        check("rst_paddle",   32'(dut_a.paddle_x), 32'd320);
        sys_rst_n = 1'b1;
        idle(2);

        for (int i = 0; i < 16; i++) begin
            @(negedge vga_clk);
            pix_x = 10'(vecs[i].x);
            pix_y = 10'(vecs[i].y);
            @(negedge vga_clk);
            check($sformatf("render_idle_%0d", i), 32'(pix_a), 32'(vecs[i].exp));
        end
        pix_x = 10'd0;
        pix_y = 10'd0;

        // start sequence: nothing moves until a tick consumes the press
        press(1);
        check("b_pending_no_tick", 32'(state_b), 32'd0);
        do_tick();
        check("b_idle_to_serve", 32'(state_b), 32'd1);
        press(1);
        do_tick();
        check("b_serve_to_play", 32'(state_b), 32'd2);

        // ball (320+4k,120+4k); at k=5 box x 330..350 straddles bricks 0 (280..339) and 1 (344..403)
        ticks(4);
        check("b_k4_bricks", 32'(dut_b.bricks), 32'b11);
        check("b_k4_ball_y", 32'(dut_b.ball_y), 32'd136);
        do_tick();
        check("b_k5_bricks", 32'(dut_b.bricks), 32'b10);
        check("b_k5_score",  32'(score_b), 32'd1);
        check("b_k5_ball_x", 32'(dut_b.ball_x), 32'd340);
        do_tick();
        check("b_k6_ball_y_up", 32'(dut_b.ball_y), 32'd136);
        check("b_k6_ball_x",    32'(dut_b.ball_x), 32'd344);

        // single brick: cleared on the first contact -> WIN, then restart
        press(2);
        do_tick();
        press(2);
        do_tick();
        ticks(4);
        check("c_k4_state", 32'(state_c), 32'd2);
        do_tick();
        check("c_win_state",  32'(state_c), 32'd5);
        check("c_win_score",  32'(score_c), 32'd1);
        check("c_win_bricks", 32'(dut_c.bricks), 32'd0);
        @(negedge vga_clk);
        pix_x = 10'd0;
        pix_y = 10'd300;
        @(negedge vga_clk);
        check("c_win_bg", 32'(pix_c), 32'h07E0);
        pix_y = 10'd0;
        press(2);
        do_tick();
        check("c_restart_state",  32'(state_c), 32'd1);
        check("c_restart_bricks", 32'(dut_c.bricks), 32'd1);
        check("c_restart_score",  32'(score_c), 32'd0);
        check("c_restart_lives",  32'(lives_c), 32'd3);
        check("c_restart_ball_y", 32'(dut_c.ball_y), 32'd120);

        // paddle held left in SERVE: 320 - 8k, clamped at 40
        press(0);
        do_tick();
        check("a_serve", 32'(state_a), 32'd1);
        left_a = 1'b0;
        idle(3);
        ticks(10);
        check("a_paddle_10", 32'(dut_a.paddle_x), 32'd240);
        ticks(90);
        check("a_paddle_clamp", 32'(dut_a.paddle_x), 32'd40);
        left_a = 1'b1;
        idle(3);

        // first miss: right wall at k=78, ny reaches 472 at k=88 far from the paddle
        press(0);
        do_tick();
        check("a_play1", 32'(state_a), 32'd2);
        run_until_lives_change(200, nframes);
        check("a_miss1_frames", 32'(nframes), 32'd88);
        check("a_miss1_lives",  32'(lives_a), 32'd2);
        check("a_miss1_state",  32'(state_a), 32'd1);
        check("a_miss1_ball_x", 32'(dut_a.ball_x), 32'd320);
        check("a_miss1_ball_y", 32'(dut_a.ball_y), 32'd120);

        // second ball with a 10-frame pause at k=20
        press(0);
        do_tick();
        ticks(20);
        check("a_pre_pause_x", 32'(dut_a.ball_x), 32'd400);
        check("a_pre_pause_y", 32'(dut_a.ball_y), 32'd200);
        press(0);
        do_tick();
        check("a_pause_state", 32'(state_a), 32'd3);
        right_a = 1'b0;
        idle(3);
        ticks(10);
        check("a_pause_ball_x", 32'(dut_a.ball_x), 32'd400);
        check("a_pause_ball_y", 32'(dut_a.ball_y), 32'd200);
        check("a_pause_paddle", 32'(dut_a.paddle_x), 32'd40);
        check("a_pause_state2", 32'(state_a), 32'd3);
        pix_a_at(0, 301, 16'h0000, "a_pause_odd_line");
        pix_a_at(0, 300, 16'hFFFF, "a_pause_even_line");
        right_a = 1'b1;
        idle(3);
        press(0);
        do_tick();
        check("a_resume_state",  32'(state_a), 32'd2);
        check("a_resume_ball_x", 32'(dut_a.ball_x), 32'd400);
        run_until_lives_change(200, nframes);
        check("a_miss2_frames", 32'(nframes), 32'd68);
        check("a_miss2_lives",  32'(lives_a), 32'd1);
        check("a_miss2_state",  32'(state_a), 32'd1);

        // third miss ends the game
        press(0);
        do_tick();
        run_until_lives_change(200, nframes);
        check("a_miss3_frames", 32'(nframes), 32'd88);
        check("a_over_lives",   32'(lives_a), 32'd0);
        check("a_over_state",   32'(state_a), 32'd4);
        pix_a_at(0, 300, 16'hF800, "a_over_bg");
        press(0);
        do_tick();
        check("a_over_restart_state", 32'(state_a), 32'd1);
        check("a_over_restart_lives", 32'(lives_a), 32'd3);
        check("a_over_restart_score", 32'(score_a), 32'd0);

        // asynchronous reset mid-play returns immediately to reset values
        ticks(3);
        @(negedge vga_clk);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("b_async_rst_state",  32'(state_b), 32'd0);
        check("b_async_rst_score",  32'(score_b), 32'd0);
        check("b_async_rst_bricks", 32'(dut_b.bricks), 32'b11);
        check("b_async_rst_ball_y", 32'(dut_b.ball_y), 32'd120);
        check("a_async_rst_lives",  32'(lives_a), 32'd3);
        check("a_async_rst_paddle", 32'(dut_a.paddle_x), 32'd320);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
